// File: rtl/auto_guesser.sv
// Binary-search player for the number-guessing game: drives Guess, reads red/green/blue feedback.
// Optional AUTO_GUESSER_ONEHOT_CHECK_EN: multiple LEDs on the sample edge send the block to FAIL.
module auto_guesser #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TRY_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             led_red,
  input  logic             led_green,
  input  logic             led_blue,
  output logic [WIDTH-1:0] Guess,
  output logic             guess_valid,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TRY_W-1:0] tries
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // GUESS | presenting a guess, holding it, sampling LEDs
  // DONE  | match found; guess and tries frozen
  // FAIL  | feedback inconsistent with any secret in range
  typedef enum logic [1:0] {S_IDLE, S_GUESS, S_DONE, S_FAIL} state_t;

  localparam int                HOLD_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [WIDTH-1:0]  MAX_VAL   = {WIDTH{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE_CYCLES - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX   = {TRY_W{1'b1}};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d, guess_q, guess_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TRY_W-1:0]  tries_q, tries_d, tries_inc;
  logic              valid_q, valid_d, done_q, done_d, fail_q, fail_d;
  logic              sample;
`ifdef AUTO_GUESSER_ONEHOT_CHECK_EN
  logic              multi_led;
  assign multi_led = (led_red & led_green) | (led_red & led_blue) | (led_green & led_blue);
`endif

  // Sum in WIDTH+1 bits so lo+hi never overflows.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  assign sample    = (hold_q == HOLD_LAST);
  assign tries_inc = (tries_q == TRY_MAX) ? tries_q : tries_q + TRY_W'(1);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    hold_d  = hold_q;
    tries_d = tries_q;
    valid_d = valid_q;
    done_d  = done_q;
    fail_d  = fail_q;
    case (state_q)
      S_GUESS: begin
        if (!sample) begin
          hold_d = hold_q + HOLD_W'(1);
        end else
`ifdef AUTO_GUESSER_ONEHOT_CHECK_EN
        if (multi_led) begin
          state_d = S_FAIL;
          valid_d = 1'b0;
          fail_d  = 1'b1;
        end else
`endif
        if (led_green) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (led_red) begin
          if (guess_q == lo_q) begin
            state_d = S_FAIL;
            valid_d = 1'b0;
            fail_d  = 1'b1;
          end else begin
            hi_d    = guess_q - WIDTH'(1);
            guess_d = midpoint(lo_q, guess_q - WIDTH'(1));
            tries_d = tries_inc;
            hold_d  = '0;
          end
        end else if (led_blue) begin
          if (guess_q == hi_q) begin
            state_d = S_FAIL;
            valid_d = 1'b0;
            fail_d  = 1'b1;
          end else begin
            lo_d    = guess_q + WIDTH'(1);
            guess_d = midpoint(guess_q + WIDTH'(1), hi_q);
            tries_d = tries_inc;
            hold_d  = '0;
          end
        end
        // No LED lit: hold counter stays at its last value so we re-sample next cycle.
      end
      default: begin
        if (start) begin
          state_d = S_GUESS;
          lo_d    = '0;
          hi_d    = MAX_VAL;
          guess_d = midpoint('0, MAX_VAL);
          hold_d  = '0;
          tries_d = TRY_W'(1);
          valid_d = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= MAX_VAL;
      guess_q <= '0;
      hold_q  <= '0;
      tries_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      hold_q  <= hold_d;
      tries_q <= tries_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign Guess       = guess_q;
  assign guess_valid = valid_q;
  assign busy        = (state_q == S_GUESS);
  assign done        = done_q;
  assign fail        = fail_q;
  assign tries       = tries_q;

endmodule

// File: tb/tb_auto_guesser.sv
// Directed bench for auto_guesser: a small responder plays the secret-holding game block.
module tb_auto_guesser;
  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;
  localparam int TRY_W  = 8;

  logic             clk = 1'b0;
  logic             reset, start;
  logic             led_red, led_green, led_blue;
  logic [WIDTH-1:0] Guess;
  logic             guess_valid, busy, done, fail;
  logic [TRY_W-1:0] tries;

  int               checks = 0;
  int               errors = 0;
  int               mode   = 0;   // 0 honest, 1 always red, 2 no LEDs, 3 red+blue
  logic [WIDTH-1:0] secret = '0;

  auto_guesser #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .TRY_W(TRY_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
    .Guess(Guess), .guess_valid(guess_valid), .busy(busy),
    .done(done), .fail(fail), .tries(tries)
  );

  always #5 clk = ~clk;

  always_comb begin
    led_red   = 1'b0;
    led_green = 1'b0;
    led_blue  = 1'b0;
    case (mode)
      0: begin
        led_red   = (Guess > secret);
        led_green = (Guess == secret);
        led_blue  = (Guess < secret);
      end
      1: led_red = 1'b1;
      3: begin
        led_red  = 1'b1;
        led_blue = 1'b1;
      end
      default: ;
    endcase
  end

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    #12;
    checks++;
    if ({Guess, guess_valid, busy, done, fail} !== '0)
      $display("FAIL reset_flags: got Guess=%0d v=%b b=%b d=%b f=%b exp all 0", Guess, guess_valid, busy, done, fail);
    checks++;
    if (tries !== 0) $display("FAIL reset_tries: got %0d exp 0", tries);
    if ({Guess, guess_valid, busy, done, fail} !== '0 || tries !== 0) errors++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_search(input int m, input logic [WIDTH-1:0] sec, input int n,
                             input logic [WIDTH-1:0] seq [5], input int exp_tries, input bit exp_fail);
    mode   = m;
    secret = sec;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < SETTLE; k++) begin
        checks++;
        if (Guess !== seq[i] || guess_valid !== 1'b1 || busy !== 1'b1 || tries !== TRY_W'(i + 1)) begin
          errors++;
          $display("FAIL search_step m=%0d sec=%0d i=%0d k=%0d: got Guess=%0d v=%b b=%b tries=%0d exp Guess=%0d v=1 b=1 tries=%0d",
                   m, sec, i, k, Guess, guess_valid, busy, tries, seq[i], i + 1);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (done !== !exp_fail || fail !== exp_fail || busy !== 1'b0 || guess_valid !== !exp_fail) begin
      errors++;
      $display("FAIL search_end m=%0d sec=%0d: got d=%b f=%b b=%b v=%b exp d=%b f=%b b=0 v=%b",
               m, sec, done, fail, busy, guess_valid, !exp_fail, exp_fail, !exp_fail);
    end
    checks++;
    if (tries !== TRY_W'(exp_tries) || Guess !== seq[n-1]) begin
      errors++;
      $display("FAIL search_result m=%0d sec=%0d: got tries=%0d Guess=%0d exp tries=%0d Guess=%0d",
               m, sec, tries, Guess, exp_tries, seq[n-1]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== !exp_fail || fail !== exp_fail || tries !== TRY_W'(exp_tries) || Guess !== seq[n-1]) begin
      errors++;
      $display("FAIL search_hold m=%0d sec=%0d: got d=%b f=%b tries=%0d Guess=%0d", m, sec, done, fail, tries, Guess);
    end
  endtask

  task automatic test_no_led();
    mode = 2;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Guess !== 4'd7 || tries !== 8'd1 || busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin
        errors++;
        $display("FAIL no_led_wait i=%0d: got Guess=%0d tries=%0d b=%b d=%b f=%b exp 7 1 1 0 0",
                 i, Guess, tries, busy, done, fail);
      end
      @(negedge clk);
    end
    mode   = 0;
    secret = 4'd7;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || tries !== 8'd1 || Guess !== 4'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_led_green: got d=%b tries=%0d Guess=%0d b=%b exp d=1 tries=1 Guess=7 b=0",
               done, tries, Guess, busy);
    end
  endtask

  task automatic test_start_ignored();
    mode   = 0;
    secret = 4'd15;
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (Guess !== 4'd11 || tries !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: got Guess=%0d tries=%0d b=%b exp Guess=11 tries=2 b=1", Guess, tries, busy);
    end
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || tries !== 8'd5 || Guess !== 4'd15) begin
      errors++;
      $display("FAIL start_ignored_end: got d=%b tries=%0d Guess=%0d exp d=1 tries=5 Guess=15", done, tries, Guess);
    end
  endtask

  task automatic test_reset_mid();
    mode   = 0;
    secret = 4'd15;
    pulse_start();
    repeat (4) @(negedge clk);
    checks++;
    if (Guess !== 4'd13 || tries !== 8'd3) begin
      errors++;
      $display("FAIL reset_mid_pre: got Guess=%0d tries=%0d exp Guess=13 tries=3", Guess, tries);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Guess, guess_valid, busy, done, fail} !== '0 || tries !== 0) begin
      errors++;
      $display("FAIL reset_mid_async: got Guess=%0d v=%b b=%b d=%b f=%b tries=%0d exp all 0",
               Guess, guess_valid, busy, done, fail, tries);
    end
    @(negedge clk);
    reset  = 1'b1;
    secret = 4'd7;
    @(negedge clk);
    pulse_start();
    checks++;
    if (Guess !== 4'd7 || tries !== 8'd1 || guess_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_restart: got Guess=%0d tries=%0d v=%b exp 7 1 1", Guess, tries, guess_valid);
    end
    repeat (SETTLE) @(negedge clk);
    checks++;
    if (done !== 1'b1 || tries !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_done: got d=%b tries=%0d exp d=1 tries=1", done, tries);
    end
  endtask

  task automatic test_multi_led();
    mode = 3;
    pulse_start();
    repeat (SETTLE) @(negedge clk);
    checks++;
`ifdef AUTO_GUESSER_ONEHOT_CHECK_EN
    if (fail !== 1'b1 || guess_valid !== 1'b0 || Guess !== 4'd7 || tries !== 8'd1) begin
      errors++;
      $display("FAIL multi_led_onehot: got f=%b v=%b Guess=%0d tries=%0d exp f=1 v=0 Guess=7 tries=1",
               fail, guess_valid, Guess, tries);
    end
`else
    if (fail !== 1'b0 || busy !== 1'b1 || Guess !== 4'd3 || tries !== 8'd2) begin
      errors++;
      $display("FAIL multi_led_priority: got f=%b b=%b Guess=%0d tries=%0d exp f=0 b=1 Guess=3 tries=2",
               fail, busy, Guess, tries);
    end
`endif
    mode = 0;
  endtask

  initial begin
    logic [WIDTH-1:0] s7   [5] = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [WIDTH-1:0] s15  [5] = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
    logic [WIDTH-1:0] s0   [5] = '{4'd7, 4'd3, 4'd1, 4'd0, 4'd0};
    start = 1'b0;
    reset = 1'b0;
    test_reset();
    test_search(0, 4'd7, 1, s7, 1, 1'b0);
    test_search(0, 4'd15, 5, s15, 5, 1'b0);
    test_search(0, 4'd0, 4, s0, 4, 1'b0);
    test_search(1, 4'd0, 4, s0, 4, 1'b1);
    test_no_led();
    test_start_ignored();
    test_reset_mid();
    test_multi_led();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/auto_guesser.md
Name: auto_guesser

Overview:
- Automatic player for the number-guessing game, the other end of the feedback interface of the secret-holding game block.
- Drives a Guess word into the game and reads back the three comparison LEDs: red means the guess is too high, blue means too low, green means a match.
- Runs a binary search over the secret range until green is seen, then reports the guess and the number of tries.
- Sits beside the game block for self-test and demo, replacing the switch inputs.

Parameters:
WIDTH, 4, bit width of Guess and of the secret range 0..2^WIDTH-1
SETTLE_CYCLES, 2, cycles each guess is held before the LEDs are sampled (minimum 1)
TRY_W, 8, width of the try counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a new search; sampled only in IDLE, DONE or FAIL
led_red  input  1  game feedback: Guess > secret
led_green  input  1  game feedback: Guess == secret
led_blue  input  1  game feedback: Guess < secret
Guess  output  WIDTH  current guess presented to the game
guess_valid  output  1  high while Guess is an active search guess
busy  output  1  high in GUESS state
done  output  1  high in DONE (match found), held
fail  output  1  high in FAIL (inconsistent feedback), held
tries  output  TRY_W  number of guesses presented in the current or last search

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; Guess=0, guess_valid=0, busy=0, done=0, fail=0, tries=0.
  - lo=0, hi=2^WIDTH-1, hold counter=0.
- States: IDLE, GUESS, DONE, FAIL.
- Start, from IDLE/DONE/FAIL with start=1 at edge E0:
  - lo=0, hi=max; Guess=(0+max)>>1 (7 for WIDTH=4).
  - tries=1, guess_valid=1, busy=1, done=0, fail=0; state=GUESS.
- In GUESS, mid is computed as (lo+hi)>>1 in WIDTH+1 bits, so there is no overflow.
- Hold and sample: Guess is held exactly SETTLE_CYCLES cycles. The hold counter counts 1..SETTLE_CYCLES, and the LEDs are sampled on the edge where it reaches SETTLE_CYCLES.
- Action on the sample edge:
  - green: state=DONE, done=1, busy=0. Guess and guess_valid stay at the matched value; tries is frozen.
  - red with Guess==lo: FAIL, since no smaller candidate remains.
  - red otherwise: hi=Guess-1.
  - blue with Guess==hi: FAIL, since no larger candidate remains.
  - blue otherwise: lo=Guess+1.
  - After a bound update, the new Guess=(lo'+hi')>>1 is loaded on that same edge, tries increments, and the hold counter restarts.
- No LED asserted: treated as not yet settled. The block stays in GUESS, re-samples every cycle, and tries does not increment.
- Multiple LEDs asserted: resolved by priority green > red > blue, unless the optional feature is compiled in.
- FAIL: guess_valid=0, busy=0, fail=1; Guess holds its last value.
- tries saturates at 2^TRY_W-1 and never wraps.
- start is ignored while in GUESS.
- A start in DONE or FAIL restarts the search on that edge, as from IDLE.
- Reset asserted mid-search returns the block to the IDLE values immediately, independent of clk.
- Worst case for WIDTH=4 is 5 guesses.

Optional Feature:
- Macro AUTO_GUESSER_ONEHOT_CHECK_EN.
- When defined: on the sample edge, any LED pattern with 2 or more bits set sends the block to FAIL (fail=1). The all-zero pattern keeps its wait behaviour.
- When undefined: green > red > blue priority applies and no extra logic is generated.

Test Plan:
- Secret 7, SETTLE_CYCLES=2 -> Guess=7 the cycle after start; green sampled 2 cycles later; done=1, tries=1, Guess=7.
- Secret 15 -> Guess sequence 7,11,13,14,15, each held 2 cycles; done=1, tries=5.
- Secret 0 -> Guess sequence 7,3,1,0; done=1, tries=4.
- Responder forcing red always -> Guess sequence 7,3,1,0, then red at Guess==lo=0; fail=1, guess_valid=0, tries=4.
- LEDs all zero for 5 cycles on the first guess, then green -> Guess stays 7, tries=1, done after green.
- Reset pulled low during the 3rd guess -> all outputs go to reset values at once; a later start gives a clean search with tries=1.
- With AUTO_GUESSER_ONEHOT_CHECK_EN defined, red+blue together on the sample edge -> fail=1.
